// File: rtl/hf_tx_pkg.sv
// Shared types and default timing for the ISO14443-A reader-side
// Modified-Miller frame encoder.
package hf_tx_pkg;

  // 13.56 MHz carrier, 106 kbit/s: 128 carrier cycles per bit slot
  localparam int DEF_BIT_CYCLES   = 128;
  localparam int DEF_PAUSE_CYCLES = 32;

  // Modified-Miller slot shapes
  //   X: pause in the second half, Y: no pause, Z: pause at slot start
  typedef enum logic [1:0] {SEQ_X, SEQ_Y, SEQ_Z} seq_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_PARITY,
    ST_EOF0,
    ST_EOF1
  } tx_state_t;

  // A 1 is always X. A 0 is Z when it follows a 0 (or SOF), else Y,
  // so two pauses never land closer than half a slot.
  function automatic seq_t miller_seq(input logic bit_val, input logic prev_zero);
    if (bit_val)        return SEQ_X;
    else if (prev_zero) return SEQ_Z;
    else                return SEQ_Y;
  endfunction

endpackage

// File: rtl/miller_slot_timer.sv
// Bit-slot timer: counts carrier cycles within one slot and renders the
// registered pause waveform for the sequence loaded at slot start.
module miller_slot_timer
  import hf_tx_pkg::*;
#(
  parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int PAUSE_CYCLES = DEF_PAUSE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  seq_t seq_in,
  output logic mod_pause,
  output logic slot_end,
  output logic pre_end
);

  localparam int CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_C  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] PRE_C   = CW'(BIT_CYCLES - 2);
  localparam logic [CW-1:0] HALF_C  = CW'(BIT_CYCLES / 2);
  localparam logic [CW-1:0] PAUSE_C = CW'(PAUSE_CYCLES);
  localparam logic [CW-1:0] XEND_C  = CW'(BIT_CYCLES / 2 + PAUSE_CYCLES);

  logic [CW-1:0] cnt;
  logic          active;
  seq_t          seq;

  // Pause level for a given sequence at slot position c
  function automatic logic pause_at(input seq_t s, input logic [CW-1:0] c);
    case (s)
      SEQ_Z:   pause_at = (c < PAUSE_C);
      SEQ_X:   pause_at = (c >= HALF_C) && (c < XEND_C);
      default: pause_at = 1'b0;
    endcase
  endfunction

  // slot_end marks the final cycle of a slot; pre_end the one before it,
  // which lets the owner register outputs that must be high on slot_end.
  assign slot_end = active && (cnt == LAST_C);
  assign pre_end  = active && (cnt == PRE_C);

  // Slot counter and pause register. mod_pause is computed from the
  // counter value it will accompany, so a slot's first cycle already
  // shows the correct level.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      active    <= 1'b0;
      seq       <= SEQ_Y;
      mod_pause <= 1'b0;
    end else if (start) begin
      cnt       <= '0;
      active    <= 1'b1;
      seq       <= seq_in;
      mod_pause <= pause_at(seq_in, '0);
    end else if (slot_end) begin
      cnt       <= '0;
      active    <= 1'b0;
      mod_pause <= 1'b0;
    end else if (active) begin
      cnt       <= cnt + CW'(1);
      mod_pause <= pause_at(seq, cnt + CW'(1));
    end
  end

endmodule

// File: rtl/hf_miller_tx_encoder.sv
// ISO14443-A reader frame encoder: turns a byte stream into the
// Modified-Miller pause waveform (SOF, data, optional odd parity, EOF).
module hf_miller_tx_encoder
  import hf_tx_pkg::*;
#(
  parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int PAUSE_CYCLES = DEF_PAUSE_CYCLES
) (
  input  logic       ck_1356meg,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  input  logic       short_frame,
  input  logic       parity_en,
  output logic       mod_pause,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  tx_state_t  state;
  logic [7:0] byte_q;
  logic [2:0] bit_idx;
  logic [2:0] last_bit;
  logic       short_q;
  logic       par_q;
  logic       last_q;
  logic       prev_zero;
  logic       ready_q;

  logic       slot_end;
  logic       pre_end;
  logic       start;
  logic       eob;
  logic       take;
  logic       use_map;
  logic       bit_nxt;
  logic       byte_tail;
  seq_t       seq_nxt;

  // ready_q is preset during reset so s_ready rises on the first free
  // cycle; the mask keeps it low while rst is held.
  assign s_ready  = ready_q & ~rst;
  assign take     = ready_q & s_valid;
  assign last_bit = short_q ? 3'd6 : 3'd7;

  // Final slot of a byte that must be followed by another byte
  // (or reported as an underrun)
  assign byte_tail = !short_q && !last_q &&
                     ((state == ST_DATA && bit_idx == last_bit && !par_q) ||
                      state == ST_PARITY);

  // Pick what the next slot carries; slots chain back-to-back, so the
  // decision is made on the last cycle of the current slot.
  always_comb begin
    start   = 1'b0;
    eob     = 1'b0;
    use_map = 1'b0;
    bit_nxt = 1'b0;
    seq_nxt = SEQ_Y;
    case (state)
      ST_IDLE: begin
        start   = take;
        seq_nxt = SEQ_Z;
      end
      ST_SOF: if (slot_end) begin
        start   = 1'b1;
        use_map = 1'b1;
        bit_nxt = byte_q[0];
      end
      ST_DATA: if (slot_end) begin
        start   = 1'b1;
        use_map = 1'b1;
        if (bit_idx != last_bit)       bit_nxt = byte_q[bit_idx + 3'd1];
        else if (par_q && !short_q)    bit_nxt = ~^byte_q;
        else                           eob     = 1'b1;
      end
      ST_PARITY: if (slot_end) begin
        start   = 1'b1;
        use_map = 1'b1;
        eob     = 1'b1;
      end
      ST_EOF0: if (slot_end) begin
        start   = 1'b1;
        seq_nxt = SEQ_Y;
      end
      default: ;
    endcase
    // End of byte: either the next byte's bit 0 or the EOF logic 0
    if (eob) bit_nxt = take ? s_data[0] : 1'b0;
    if (use_map) seq_nxt = miller_seq(bit_nxt, prev_zero);
  end

  // Frame FSM, byte/bit tracking and registered status outputs
  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      state      <= ST_IDLE;
      byte_q     <= '0;
      bit_idx    <= '0;
      short_q    <= 1'b0;
      par_q      <= 1'b0;
      last_q     <= 1'b0;
      prev_zero  <= 1'b0;
      ready_q    <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      // SOF counts as a zero for the following element
      if (start) prev_zero <= (state == ST_IDLE) | ~bit_nxt;
      case (state)
        ST_IDLE: if (start) begin
          byte_q  <= s_data;
          short_q <= short_frame;
          par_q   <= parity_en;
          last_q  <= s_last;
          bit_idx <= '0;
          ready_q <= 1'b0;
          busy    <= 1'b1;
          state   <= ST_SOF;
        end
        ST_SOF: if (slot_end) begin
          state   <= ST_DATA;
          bit_idx <= '0;
        end
        ST_DATA: if (slot_end && !eob) begin
          if (bit_idx != last_bit) bit_idx <= bit_idx + 3'd1;
          else                     state   <= ST_PARITY;
        end
        ST_EOF0: if (slot_end) state <= ST_EOF1;
        ST_EOF1: if (slot_end) begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b1;
          ready_q    <= 1'b1;
        end
        default: ;
      endcase
      // Byte boundary: chain the next byte or close the frame
      if (eob) begin
        ready_q <= 1'b0;
        if (take) begin
          byte_q  <= s_data;
          last_q  <= s_last;
          bit_idx <= '0;
          state   <= ST_DATA;
        end else begin
          state    <= ST_EOF0;
          underrun <= !short_q && !last_q;
        end
      end
      // Open the input window for exactly the byte's last cycle
      if (pre_end && byte_tail) ready_q <= 1'b1;
    end
  end

  miller_slot_timer #(
    .BIT_CYCLES  (BIT_CYCLES),
    .PAUSE_CYCLES(PAUSE_CYCLES)
  ) u_timer (
    .clk      (ck_1356meg),
    .rst      (rst),
    .start    (start),
    .seq_in   (seq_nxt),
    .mod_pause(mod_pause),
    .slot_end (slot_end),
    .pre_end  (pre_end)
  );

endmodule
